// File: rtl/alu_issue.sv
// alu_issue: issues one R-type instruction at a time to the ALU and writes the result back.
// Ports: clk/rst, instr_valid/instr_ready/instr in, rf read (ra1/ra2, rd1/rd2), ALU
//   operands (alu_a/b/shamt/funct/go, alu_out), writeback (rf_we/wa/wd), done/err, retired.
module alu_issue #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [4:0]  rf_ra1,
   output logic [4:0]  rf_ra2,
   input  logic [31:0] rf_rd1,
   input  logic [31:0] rf_rd2,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_shamt,
   output logic [5:0]  alu_funct,
   output logic        alu_go,
   input  logic [31:0] alu_out,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        done,
   output logic        err,
   output logic [15:0] retired
);

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      WB    = 3'd4
   } state_t;

   state_t      state_q, state_d;

   logic        ready_q, ready_d;
   logic [4:0]  ra1_q, ra1_d;
   logic [4:0]  ra2_q, ra2_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  sh_q, sh_d;
   logic [5:0]  fn_q, fn_d;
   logic        go_q, go_d;
   logic        we_q, we_d;
   logic [4:0]  wa_q, wa_d;
   logic [31:0] wd_q, wd_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] ret_q, ret_d;
   logic [3:0]  cnt_q, cnt_d;

   // Latched instruction fields
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  ishamt_q, ishamt_d;
   logic [5:0]  ifunct_q, ifunct_d;

   logic        accept;
   logic        legal;
   logic        is_shift;
   logic        alu_last;
   logic        hilo_only;

   function automatic logic legal_instr(input logic [31:0] w);
      logic ok;
      case (w[5:0])
         6'h00, 6'h02, 6'h03, 6'h10,
         6'h12, 6'h18, 6'h1A, 6'h20,
         6'h22, 6'h24, 6'h25, 6'h26,
         6'h27, 6'h2A: ok = 1'b1;
         default:      ok = 1'b0;
      endcase
      return ok && (w[31:26] == 6'd0);
   endfunction

   assign accept    = (state_q == IDLE) && instr_valid && ready_q;
   assign legal     = legal_instr(instr);
   assign is_shift  = (ifunct_q == 6'h00) || (ifunct_q == 6'h02)
                   || (ifunct_q == 6'h03);
   assign alu_last  = (state_q == WAIT) && (cnt_q == 4'd0);
   // mul/div only update the ALU's hi/lo pair
   assign hilo_only = (ifunct_q == 6'h18) || (ifunct_q == 6'h1A);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = legal ? READ : WB;
         end
         READ:  state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (cnt_q == 4'd0) state_d = WB;
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      ready_d  = (state_d == IDLE);
      ra1_d    = ra1_q;
      ra2_d    = ra2_q;
      a_d      = a_q;
      b_d      = b_q;
      sh_d     = sh_q;
      fn_d     = fn_q;
      go_d     = (state_q == READ);
      we_d     = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      ret_d    = ret_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      ishamt_d = ishamt_q;
      ifunct_d = ifunct_q;

      if (accept) begin
         rd_d     = instr[15:11];
         ishamt_d = instr[10:6];
         ifunct_d = instr[5:0];
         if (legal) begin
            ra1_d = instr[25:21];
            ra2_d = instr[20:16];
         end else begin
            wa_d   = instr[15:11];
            done_d = 1'b1;
            err_d  = 1'b1;
         end
      end

      // Register data arrives during READ; shifts operate on rt
      if (state_q == READ) begin
         a_d  = is_shift ? rf_rd2 : rf_rd1;
         b_d  = is_shift ? 32'd0 : rf_rd2;
         sh_d = is_shift ? ishamt_q : 5'd0;
         fn_d = ifunct_q;
      end

      if (state_q == ISSUE) cnt_d = LAT_M1;

      if (state_q == WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;

      if (alu_last) begin
         wd_d   = alu_out;
         wa_d   = rd_q;
         we_d   = !hilo_only && (rd_q != 5'd0);
         done_d = 1'b1;
         ret_d  = ret_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q  <= 1'b0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sh_q     <= '0;
         fn_q     <= '0;
         go_q     <= 1'b0;
         we_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ret_q    <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
         ishamt_q <= '0;
         ifunct_q <= '0;
      end else begin
         ready_q  <= ready_d;
         ra1_q    <= ra1_d;
         ra2_q    <= ra2_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sh_q     <= sh_d;
         fn_q     <= fn_d;
         go_q     <= go_d;
         we_q     <= we_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ret_q    <= ret_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         ishamt_q <= ishamt_d;
         ifunct_q <= ifunct_d;
      end
   end

   assign instr_ready = ready_q;
   assign rf_ra1      = ra1_q;
   assign rf_ra2      = ra2_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_shamt   = sh_q;
   assign alu_funct   = fn_q;
   assign alu_go      = go_q;
   assign rf_we       = we_q;
   assign rf_wa       = wa_q;
   assign rf_wd       = wd_q;
   assign done        = done_q;
   assign err         = err_q;
   assign retired     = ret_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

R-type issue/writeback controller acting as the initiator on the ALU's operand/funct/go interface. It accepts one instruction word at a time, decodes the R-type fields, and reads the two source registers from the register file. It then drives the ALU operands, shamt and funct with a single-cycle `go` pulse, samples the ALU result, and writes it back to `rd`. It sits between instruction fetch and the register file/ALU pair and serialises one instruction at a time.

## Interface
- `ALU_LAT`, default 1: cycles from the `alu_go` cycle to `alu_out` sampling. Legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word offered.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `instr`  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- `rf_ra1`  out  5  register file read address, port 1.
- `rf_ra2`  out  5  register file read address, port 2.
- `rf_rd1`  in  32  read data for port 1, valid one cycle after its address.
- `rf_rd2`  in  32  read data for port 2, valid one cycle after its address.
- `alu_a`  out  32  ALU operand a.
- `alu_b`  out  32  ALU operand b.
- `alu_shamt`  out  5  shift amount.
- `alu_funct`  out  6  function code.
- `alu_go`  out  1  issue strobe; the ALU acts on its rising edge.
- `alu_out`  in  32  ALU result.
- `rf_we`  out  1  writeback enable, one-cycle pulse.
- `rf_wa`  out  5  writeback address.
- `rf_wd`  out  32  writeback data.
- `done`  out  1  one-cycle pulse when an instruction retires, legal or illegal.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal instruction.
- `retired`  out  16  count of legal retired instructions; wraps 0xFFFF→0x0000.

## Operation
- **FSM states:** IDLE, READ, ISSUE, WAIT, WB.
- **IDLE:** `instr_ready`=1. On `instr_valid`&`instr_ready`:
  - Latch the instruction fields.
  - Register `rf_ra1`=rs and `rf_ra2`=rt.
  - Go to READ, or to WB with the illegal flag set.
- **Legal instruction:** opcode==0 and funct ∈ {00,02,03,10,12,18,1A,20,22,24,25,26,27,2A}. Anything else is illegal:
  - no register read, no `alu_go`, no `rf_we`;
  - `done`=`err`=1 in WB.
- **READ:** one cycle waiting on register file data. At the exit edge, capture operands:
  - Shifts (funct 00/02/03): `alu_a`←`rf_rd2` (rt), `alu_b`←0.
  - All others: `alu_a`←`rf_rd1` (rs), `alu_b`←`rf_rd2` (rt).
  - `alu_shamt`←shamt for shifts, 0 otherwise.
  - `alu_funct`←funct.
- **ISSUE:** `alu_go`=1 for exactly this cycle. Operands stay stable from ISSUE through the end of WAIT.
- **WAIT:** ALU_LAT cycles, counted by a 4-bit down-counter. `alu_out` is sampled into the `rf_wd` register at the last WAIT edge.
- **WB:** one cycle.
  - `rf_we`=1 iff the instruction is legal, funct ∉ {18,1A}, and rd≠0.
  - `rf_wa`=rd.
  - `done`=1.
  - `retired` increments for every legal instruction, including ones with rd=0 and funct 18/1A.
  - Return to IDLE.
- **Write suppression:** funct 18 (mul) and 1A (div) update the ALU's hi/lo only and never write back. funct 10/12 write hi/lo into rd normally.
- **`alu_go` spacing:** `alu_go` is low for at least 3 cycles between consecutive pulses, so every issue presents a fresh rising edge.
- **Reset** (any state, including mid-operation): next state IDLE. The in-flight instruction is dropped with no `rf_we`, `done` or `err`.
- **Reset values:**
  - `instr_ready`=0 while `rst`=1, and 1 from the first cycle after release.
  - `rf_ra1`, `rf_ra2`, `alu_a`, `alu_b`, `alu_shamt`, `alu_funct`, `rf_wa`, `rf_wd` = 0.
  - `alu_go`, `rf_we`, `done`, `err` = 0.
  - `retired` = 0.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- Cycle numbering, with the accept cycle as cycle 0:
  - Cycle 1: READ.
  - Cycle 2: ISSUE (`alu_go`=1).
  - Cycles 3..2+ALU_LAT: WAIT.
  - Cycle 3+ALU_LAT: WB (`rf_we`, `done`).
- `instr_ready` returns in cycle 4+ALU_LAT, so legal throughput is one instruction per 4+ALU_LAT cycles.
- Illegal instruction: WB in cycle 1, `instr_ready` again in cycle 2.
- `instr_valid` held high across a busy period is not accepted until IDLE. No instruction is lost or duplicated.
- WB and the next accept never share a cycle.

## Test plan
- **add:** ALU_LAT=1, R1=5, R2=7, add $3,$1,$2 (instr 0x00221820) → `alu_go` in cycle 2 with a=5, b=7, funct=20; `rf_we`=1, `rf_wa`=3, `rf_wd`=12 in cycle 4; `done`=1, `retired`=1.
- **shift:** sll $4,$2,3 with R2=0x1 → `alu_a`=0x1, `alu_shamt`=3, funct=00; `rf_wd`=0x8 to R4.
- **mul then mflo:** mul (funct 18) with R1=6, R2=7 → `alu_go` pulses, no `rf_we`, `done`=1. Then mflo $5 → R5=42. `alu_go` shows two distinct rising edges.
- **illegal and rd=0:** opcode 0x23 → `done`=`err`=1 in cycle 1, no `alu_go`, no `rf_we`, `retired` unchanged. add with rd=0 → no `rf_we`, `done`=1, `retired`+1.
- **reset mid-flight:** `rst` asserted in cycle 2 of an add → no `rf_we`/`done` afterwards, all outputs at reset values, `instr_ready`=1 the cycle after `rst` falls.
- **back-to-back and wrap:** ALU_LAT=3, `instr_valid` held high with 3 queued adds → WB in cycles 6, 13, 20. Preload `retired` to 0xFFFF via 65535 legal instructions, retire one more → `retired`=0x0000.
